memory_responder: RTL

Target side of the CPU's RAM bus: a 16 x 8 word memory that answers the controller's read/write enables, address and bidirectional data bus. After reset it runs a boot-load phase that fills the memory from a valid/ready byte stream, then serves bus accesses. It also flags illegal bus conditions, such as both enables asserted together. It sits between the control unit's memory port and the program loader.

---
 rtl/memory_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// RAM-bus target: 16x8 memory with a boot-load phase fed by a byte stream.
// Serves CPU reads/writes on a shared tristate bus and flags illegal requests.
module memory_responder #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_read_en,
  input  logic              ram_write_en,
  input  logic [ADDR_W-1:0] ram_address,
  inout  wire  [WIDTH-1:0]  ram_data,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_ready,
  output logic              busy,
  output logic              bus_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_LOAD,
    S_SERVE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_load_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd;
  logic              r_drive;
  logic              r_err;

  logic w_load;
  logic w_serve;
  logic w_ld;
  logic w_rd;
  logic w_wr;
  logic w_conf;
  logic w_ld_err;
  logic w_last;

  assign w_load   = (r_state == S_LOAD);
  assign w_serve  = (r_state == S_SERVE);
  assign w_ld     = w_load && load_valid;
  assign w_last   = &r_load_ptr;
  assign w_ld_err = w_load && (ram_read_en || ram_write_en);

  // load_req wins over any bus request issued in the same cycle
  always_comb begin
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_conf = 1'b0;
    if (w_serve && !load_req) begin
      unique case (1'b1)
        ram_read_en && ram_write_en:  w_conf = 1'b1;
        ram_read_en && !ram_write_en: w_rd   = 1'b1;
        ram_write_en && !ram_read_en: w_wr   = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LOAD;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD:  if (w_ld && w_last) w_next = S_SERVE;
      S_SERVE: if (load_req)       w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_comb begin
    load_ready = w_load;
    busy       = w_load;
    bus_err    = r_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_ptr <= '0;
      r_rd       <= '0;
      r_drive    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_drive <= w_rd;
      if (w_rd) r_rd <= r_mem[ram_address];
      if (w_conf || w_ld_err) r_err <= 1'b1;
      if (w_serve && load_req) r_load_ptr <= '0;
      else if (w_ld)           r_load_ptr <= r_load_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_ld) begin
      r_mem[r_load_ptr] <= load_data;
    end else if (w_wr) begin
      r_mem[ram_address] <= ram_data;
    end
  end

  assign ram_data = r_drive ? r_rd : {WIDTH{1'bz}};

endmodule
